bram_seq_reader: RTL

Sequential read-back engine for the single-port BRAM (xilinx_single_port_ram_no_change); it is the reader counterpart of the sequential address-pattern writer.
- On `start`, issues `len` consecutive reads from `base_addr`, wrapping modulo RAM_DEPTH.
- Absorbs the RAM read latency and streams words out on a valid/ready interface with `last`.
- Sits between the BRAM port and downstream processing or checking logic.

---
 rtl/bram_pkg.sv | 21 ++
 rtl/bram_rd_fifo.sv | 52 +++++
 rtl/bram_seq_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// bram_pkg: shared helpers and FSM state encoding for the BRAM sequential reader.
package bram_pkg;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    function automatic int clogb2(input int depth);
        int d = depth;
        int n = 0;
        while (d > 0) begin
            n++;
            d = d >> 1;
        end
        return n;
    endfunction

    // Output register of the BRAM adds one cycle in high-performance mode.
    function automatic int read_lat(input logic [8*16-1:0] perf);
        return (perf == "HIGH_PERFORMANCE") ? 2 : 1;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// bram_rd_fifo: small synchronous FIFO whose head drives the stream outputs directly.
module bram_rd_fifo
    import bram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic [clogb2(DEPTH)-1:0]   count_o
);

    localparam int PW = clogb2(DEPTH - 1);
    localparam int CW = clogb2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;

    assign do_pop  = pop_i && count_q != '0;
    assign data_o  = mem_q[rd_q];
    assign valid_o = count_q != '0;
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            end
            if (do_pop)
                rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    // A full FIFO may only accept a push in the same cycle it pops.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && count_q == CW'(DEPTH)));

endmodule

// File: rtl/bram_seq_reader.sv
// bram_seq_reader: issues len consecutive BRAM reads from base_addr and streams them out.
// Optional data=address checker enabled by defining BRAM_RD_CHECK_EN.
module bram_seq_reader
    import bram_pkg::*;
#(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int ADDR_W         = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      len,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic                 ram_regcea,
    output logic [ADDR_W-1:0]    ram_addra,
    input  logic [RAM_WIDTH-1:0] ram_douta,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [ADDR_W:0]      err_cnt,
    output logic                 err
);

    localparam int READ_LAT   = read_lat(RAM_PERFORMANCE);
    localparam int FIFO_DEPTH = READ_LAT + 2;

    state_t                       state_q;
    logic                         done_q;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [ADDR_W:0]              len_q, issued_q;
    logic [READ_LAT-1:0]          pipe_v_q, pipe_l_q;
    logic [clogb2(FIFO_DEPTH)-1:0] fifo_cnt;
    int                           inflight;
    logic                         start_acc, pop, issue, last_issue, drained;

    assign inflight   = $countones(pipe_v_q);
    assign start_acc  = state_q == S_IDLE && start;
    assign pop        = m_valid && m_ready;
    // Credits cover every word already in the pipe or FIFO, so a push never finds it full.
    assign issue      = state_q == S_READ && (inflight + int'(fifo_cnt) - int'(pop) < FIFO_DEPTH);
    assign last_issue = issued_q == len_q - 1'b1;
    assign drained    = inflight == 0 && int'(fifo_cnt) - int'(pop) == 0;
    assign addr_d     = (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

    assign busy       = state_q != S_IDLE;
    assign done       = done_q;
    assign ram_ena    = issue;
    assign ram_wea    = 1'b0;
    assign ram_regcea = busy;
    assign ram_addra  = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            pipe_v_q <= '0;
            pipe_l_q <= '0;
        end else begin
            pipe_v_q[0] <= issue;
            pipe_l_q[0] <= issue && last_issue;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1];
                pipe_l_q[i] <= pipe_l_q[i-1];
            end
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    addr_q   <= base_addr;
                    len_q    <= len;
                    issued_q <= '0;
                    state_q  <= (len == '0) ? S_DONE : S_READ;
                    done_q   <= len == '0;
                end
                S_READ: if (issue) begin
                    addr_q   <= addr_d;
                    issued_q <= issued_q + 1'b1;
                    if (last_issue) state_q <= S_DRAIN;
                end
                S_DRAIN: if (drained) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    bram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RAM_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pipe_v_q[READ_LAT-1]),
        .data_i  ({pipe_l_q[READ_LAT-1], ram_douta}),
        .pop_i   (pop),
        .data_o  ({m_last, m_data}),
        .valid_o (m_valid),
        .count_o (fifo_cnt)
    );

`ifdef BRAM_RD_CHECK_EN
    logic [ADDR_W-1:0] chk_addr_q;
    logic [ADDR_W:0]   err_cnt_q;
    logic              err_q;
    logic              mismatch;

    assign mismatch = pop && m_data != RAM_WIDTH'(chk_addr_q);
    assign err_cnt  = err_cnt_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_addr_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else if (start_acc) begin
            chk_addr_q <= base_addr;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else if (pop) begin
            chk_addr_q <= (chk_addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : chk_addr_q + 1'b1;
            if (mismatch) begin
                err_q     <= 1'b1;
                err_cnt_q <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
            end
        end
    end
`else
    assign err_cnt = '0;
    assign err     = 1'b0;
`endif

endmodule
